// File: rtl/sb_codex_pkg.sv
// Shared sideband definitions: message codes, payload length encoding and the
// request entry buffered by the transmit scheduler.
package SB_codex_pkg;

    typedef enum logic [7:0] {
        SB_MSG_NONE        = 8'h00,
        SB_MSG_OOR         = 8'h01,
        SB_MSG_DONE_REQ    = 8'h02,
        SB_MSG_DONE_RESP   = 8'h03,
        SB_MSG_PARAM_REQ   = 8'h04,
        SB_MSG_PARAM_RESP  = 8'h05,
        SB_MSG_MBINIT_REQ  = 8'h06,
        SB_MSG_MBINIT_RESP = 8'h07,
        SB_MSG_REG_RD      = 8'h08,
        SB_MSG_REG_WR      = 8'h09,
        SB_MSG_REG_CPL     = 8'h0A,
        SB_MSG_TRAIN_ERR   = 8'h0B
    } SB_msg_t;

    typedef enum logic [1:0] {
        SB_LEN_NONE = 2'd0,
        SB_LEN_32   = 2'd1,
        SB_LEN_64   = 2'd2
    } sb_len_t;

    localparam int SB_TX_GAP_CYCLES = 12;

    typedef struct packed {
        SB_msg_t     msg;
        logic [63:0] data;
        sb_len_t     len;
    } sb_entry_t;

endpackage

// File: rtl/sb_msg_fifo.sv
// Synchronous request FIFO; full/empty come from a level counter so the
// pointers can simply wrap modulo DEPTH.
module sb_msg_fifo
    import SB_codex_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  sb_entry_t                din,
    output sb_entry_t                dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    sb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (!do_push && do_pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/sb_tx_scheduler.sv
// Sideband transmit scheduler: buffers requests and launches header/payload
// beats with a minimum spacing so the 800MHz serialiser buffer cannot overflow.
module sb_tx_scheduler
    import SB_codex_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = SB_TX_GAP_CYCLES
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  SB_msg_t                req_msg_i,
    input  logic [63:0]            req_data_i,
    input  logic [1:0]             req_len_i,
    input  logic                   send_next_flag_i,
    output logic                   tx_valid_o,
    output SB_msg_t                tx_msg_o,
    output logic [63:0]            tx_data_o,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic                   busy_o
);
    localparam int GW = $clog2(2 * GAP_CYCLES + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_WAIT_DATA, ST_DATA, ST_GAP} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          tx_valid_q, tx_valid_d;
    SB_msg_t       tx_msg_q, tx_msg_d;
    logic [63:0]   tx_data_q, tx_data_d;

    sb_entry_t     fifo_din, head;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign req_ready_o = !reset && enable_i && !fifo_full;
    assign fifo_push   = req_valid_i && req_ready_o;

    // Length code 3 is folded into 64b; 32b payloads are zero-extended on entry.
    always_comb begin
        fifo_din.msg = req_msg_i;
        case (req_len_i)
            2'd0:    fifo_din.len = SB_LEN_NONE;
            2'd1:    fifo_din.len = SB_LEN_32;
            default: fifo_din.len = SB_LEN_64;
        endcase
        fifo_din.data = (req_len_i == 2'd1) ? {32'd0, req_data_i[31:0]} : req_data_i;
    end

    sb_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_100MHz),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (!enable_i),
        .din   (fifo_din),
        .dout  (head),
        .level (fifo_level_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tx_valid_d = 1'b0;
        tx_msg_d   = tx_msg_q;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            gap_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && send_next_flag_i && gap_q == '0) begin
                        state_d    = ST_HDR;
                        tx_valid_d = 1'b1;
                        tx_msg_d   = head.msg;
                        tx_data_d  = head.data;
                    end
                end
                ST_HDR: begin
                    if (head.len == SB_LEN_NONE) begin
                        fifo_pop = 1'b1;
                        gap_d    = GW'(GAP_CYCLES);
                        state_d  = ST_GAP;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (send_next_flag_i) begin
                        state_d    = ST_DATA;
                        tx_valid_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    fifo_pop = 1'b1;
                    gap_d    = GW'(2 * GAP_CYCLES);
                    state_d  = ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q <= GW'(1)) begin
                        gap_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_msg_q   <= SB_MSG_NONE;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_valid_q <= tx_valid_d;
            tx_msg_q   <= tx_msg_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_msg_o   = tx_msg_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (fifo_level_o != '0) || (state_q != ST_IDLE);

endmodule
